// File: rtl/dili_pkg.sv
// dili_pkg: shared constants and per-mode bit width / offset tables for Dilithium packing
package dili_pkg;
  localparam int Q = 8380417;
  localparam logic [2:0] ENC_T1  = 3'd0;
  localparam logic [2:0] ENC_T0  = 3'd1;
  localparam logic [2:0] ENC_ETA = 3'd2;
  localparam logic [2:0] ENC_Z   = 3'd3;
  localparam logic [2:0] ENC_W1  = 3'd4;
  typedef struct packed {
    logic        raw;
    logic [19:0] k;
  } enc_off_t;
  function automatic logic [2:0] norm_mode(input logic [2:0] m);
    return (m > ENC_W1) ? ENC_T1 : m;
  endfunction
  function automatic logic [2:0] norm_sec(input logic [2:0] s);
    return (s == 3'd3 || s == 3'd5) ? s : 3'd2;
  endfunction
  // mode and sec are expected to be normalised already
  function automatic logic [4:0] enc_bits(input logic [2:0] mode, input logic [2:0] sec);
    return mode == ENC_T0  ? 5'd13 :
           mode == ENC_ETA ? (sec == 3'd3 ? 5'd4 : 5'd3) :
           mode == ENC_Z   ? (sec == 3'd2 ? 5'd18 : 5'd20) :
           mode == ENC_W1  ? (sec == 3'd2 ? 5'd6 : 5'd4) : 5'd10;
  endfunction
  function automatic enc_off_t enc_offset(input logic [2:0] mode, input logic [2:0] sec);
    enc_off_t o;
    o.raw = (mode == ENC_T1) || (mode == ENC_W1);
    o.k   = mode == ENC_T0  ? 20'd4096 :
            mode == ENC_ETA ? (sec == 3'd3 ? 20'd4 : 20'd2) :
            mode == ENC_Z   ? (sec == 3'd2 ? 20'h20000 : 20'h80000) : 20'd0;
    return o;
  endfunction
endpackage

// File: rtl/dili_coeff_map.sv
// dili_coeff_map: maps one coefficient to (K - c) mod q (or raw c), truncated to b bits
module dili_coeff_map
  import dili_pkg::*;
(
  input  logic [22:0] i_c,
  input  logic [19:0] i_k,
  input  logic        i_raw,
  input  logic [4:0]  i_b,
  output logic [19:0] o_v
);
  logic [23:0] w_d;
  logic [23:0] w_m;
  assign w_d = {4'b0, i_k} - {1'b0, i_c};
  assign w_m = i_raw ? {1'b0, i_c} : (w_d[23] ? w_d + 24'(Q) : w_d);
  assign o_v = 20'(w_m & ((24'd1 << i_b) - 24'd1));
endmodule

// File: rtl/dili_poly_encoder.sv
// dili_poly_encoder: packs mode-mapped coefficients little-endian into 64-bit words
module dili_poly_encoder
  import dili_pkg::*;
#(
  parameter int INPUT_W = 4,
  parameter int COEFF_W = 23,
  parameter int W       = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 sec_lvl,
  input  logic [2:0]                 encode_modei,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [INPUT_W*COEFF_W-1:0] samples,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [W-1:0]               dout,
  output logic                       last_o
);
  logic [143:0] r_buf;
  logic [7:0]   r_fill;
  logic [5:0]   r_bcnt;
  logic [6:0]   r_wcnt;
  logic [2:0]   r_mode;
  logic [2:0]   r_sec;
  logic         r_en;
  logic [2:0]   w_mode;
  logic [2:0]   w_sec;
  logic [4:0]   w_b;
  enc_off_t     w_off;
  logic [19:0]  w_v [INPUT_W];
  logic [79:0]  w_pack;
  logic [6:0]   w_lastw;
  logic         w_push;
  logic         w_pop;
  // beat 0 uses the live controls so the first beat maps with the mode it latches
  assign w_mode  = (r_bcnt == 6'd0) ? norm_mode(encode_modei) : r_mode;
  assign w_sec   = (r_bcnt == 6'd0) ? norm_sec(sec_lvl) : r_sec;
  assign w_b     = enc_bits(w_mode, w_sec);
  assign w_off   = enc_offset(w_mode, w_sec);
  assign w_lastw = {enc_bits(r_mode, r_sec), 2'b0} - 7'd1;
  assign ready_o = r_en && (r_fill < 8'd64);
  assign valid_o = r_fill >= 8'd64;
  assign dout    = r_buf[W-1:0];
  assign last_o  = valid_o && (r_wcnt == w_lastw);
  assign w_push  = valid_i && ready_o;
  assign w_pop   = valid_o && ready_i;
  for (genvar k = 0; k < INPUT_W; k++) begin : g_map
    dili_coeff_map u_map (
      .i_c  (samples[k*COEFF_W +: COEFF_W]),
      .i_k  (w_off.k),
      .i_raw(w_off.raw),
      .i_b  (w_b),
      .o_v  (w_v[k])
    );
  end
  always_comb begin
    w_pack = '0;
    for (int j = 0; j < INPUT_W; j++) w_pack = w_pack | (80'(w_v[j]) << (j * int'(w_b)));
  end
  // ready_o and valid_o split on fill, so a push and a pop never coincide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf  <= '0;
      r_fill <= '0;
      r_bcnt <= '0;
      r_wcnt <= '0;
      r_mode <= ENC_T1;
      r_sec  <= 3'd2;
      r_en   <= 1'b0;
    end else begin
      r_en <= 1'b1;
      if (w_push) begin
        r_buf  <= r_buf | (144'(w_pack) << r_fill);
        r_fill <= r_fill + {1'b0, w_b, 2'b0};
        r_bcnt <= r_bcnt + 6'd1;
        r_mode <= w_mode;
        r_sec  <= w_sec;
      end else if (w_pop) begin
        r_buf  <= r_buf >> W;
        r_fill <= r_fill - 8'(W);
        r_wcnt <= last_o ? 7'd0 : r_wcnt + 7'd1;
      end
    end
  end
endmodule

// File: tb/tb_dili_poly_encoder.sv
// tb_dili_poly_encoder: vector table plus random polynomials checked against a bit-queue model
module tb_dili_poly_encoder;
  localparam int Q = 8380417;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  sec_lvl = '0;
  logic [2:0]  encode_modei = '0;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [91:0] samples = '0;
  logic        ready_o;
  logic        valid_o;
  logic        last_o;
  logic [63:0] dout;
  dili_poly_encoder dut (
    .clk(clk), .rst(rst), .sec_lvl(sec_lvl), .encode_modei(encode_modei),
    .valid_i(valid_i), .ready_o(ready_o), .samples(samples),
    .valid_o(valid_o), .ready_i(ready_i), .dout(dout), .last_o(last_o)
  );
  always #5 clk = ~clk;
  typedef struct {logic [63:0] d; logic l;} word_t;
  typedef struct {string nm; int md; int sc; int c; int chg; int stall; int nw; logic [63:0] w0;} vec_t;
  int n_tests = 0;
  int n_fail = 0;
  int rdy_mode = 0;
  word_t wq[$];
  bit bitq[$];
  int m_beat = 0;
  int m_mode = 0;
  int m_sec = 2;
  bit m_en = 0;
  int p_words = 0;
  int p_last = 0;
  int p_last_idx = 0;
  logic [63:0] p_w0 = '0;
  vec_t tv[9];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic int norm_m(input int m);
    return m > 4 ? 0 : m;
  endfunction
  function automatic int norm_s(input int s);
    return (s == 3 || s == 5) ? s : 2;
  endfunction
  function automatic int bits_of(input int m, input int s);
    case (m)
      1: return 13;
      2: return s == 3 ? 4 : 3;
      3: return s == 2 ? 18 : 20;
      4: return s == 2 ? 6 : 4;
      default: return 10;
    endcase
  endfunction
  function automatic int k_of(input int m, input int s);
    case (m)
      1: return 4096;
      2: return s == 3 ? 4 : 2;
      3: return s == 2 ? (1 << 17) : (1 << 19);
      default: return -1;
    endcase
  endfunction
  function automatic int vmap(input int m, input int s, input int c);
    int k;
    int v;
    k = k_of(m, s);
    v = (k < 0) ? c : (((k - c) % Q) + Q) % Q;
    return v & ((1 << bits_of(m, s)) - 1);
  endfunction
  function automatic void push_model();
    int b;
    int v;
    word_t w;
    if (m_beat == 0) begin
      m_mode = norm_m(int'(encode_modei));
      m_sec  = norm_s(int'(sec_lvl));
    end
    b = bits_of(m_mode, m_sec);
    for (int k = 0; k < 4; k++) begin
      v = vmap(m_mode, m_sec, int'(samples[23*k +: 23]));
      for (int j = 0; j < b; j++) bitq.push_back(v[j]);
    end
    m_beat = (m_beat + 1) % 64;
    while (bitq.size() >= 64) begin
      for (int j = 0; j < 64; j++) w.d[j] = bitq.pop_front();
      w.l = (m_beat == 0) && (bitq.size() == 0);
      wq.push_back(w);
    end
  endfunction
  function automatic void pop_model();
    if (p_words == 0) p_w0 = dout;
    p_words++;
    if (last_o) begin
      p_last++;
      p_last_idx = p_words;
    end
    void'(wq.pop_front());
  endfunction
  always @(posedge clk) begin
    #1;
    ready_i = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ($urandom_range(0, 3) != 0) : 1'b0;
  end
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_en = 0;
      m_beat = 0;
      wq.delete();
      bitq.delete();
    end else m_en = 1;
  end
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", valid_o, 0);
      chk("rst_ready", ready_o, 0);
      chk("rst_dout", dout, 0);
      chk("rst_last", last_o, 0);
    end else begin
      int fill;
      fill = 64 * wq.size() + bitq.size();
      chk("ready_o", ready_o, m_en && fill < 64);
      chk("valid_o", valid_o, fill >= 64);
      if (fill >= 64) begin
        chk("dout", dout, wq[0].d);
        chk("last_o", last_o, wq[0].l);
      end else chk("last_idle", last_o, 0);
      if (valid_i && ready_o) push_model();
      else if (valid_o && ready_i && wq.size() > 0) pop_model();
    end
  end
  task automatic send_beat(input int md, input int sc, input int c);
    int n = 0;
    bit acc = 0;
    encode_modei = 3'(md);
    sec_lvl = 3'(sc);
    for (int k = 0; k < 4; k++) samples[23*k +: 23] = 23'(c < 0 ? int'($urandom_range(0, Q - 1)) : c);
    valid_i = 1'b1;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
  endtask
  task automatic run_poly(input vec_t v, input int rdy, input bit chk_w0);
    int n = 0;
    p_words = 0;
    p_last = 0;
    p_last_idx = 0;
    rdy_mode = v.stall > 0 ? 2 : rdy;
    for (int b = 0; b < 64; b++) begin
      // hold the stream with a full word waiting and no downstream ready
      if (v.stall > 0 && b == v.stall) begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("bp_valid", valid_o, 1);
          chk("bp_ready", ready_o, 0);
          chk("bp_dout", dout, v.w0);
          chk("bp_last", last_o, 0);
        end
        chk("bp_noaccept", m_beat, v.stall);
        rdy_mode = rdy;
        @(posedge clk);
        #1;
      end
      if (v.chg > 0 && b >= v.chg) send_beat($urandom_range(0, 7), $urandom_range(0, 7), v.c);
      else send_beat(v.md, v.sc, v.c);
    end
    valid_i = 1'b0;
    while ((wq.size() != 0 || bitq.size() != 0) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({v.nm, "_drain"}, n < 1000, 1);
    chk({v.nm, "_words"}, p_words, v.nw);
    chk({v.nm, "_lastcnt"}, p_last, 1);
    chk({v.nm, "_lastidx"}, p_last_idx, v.nw);
    if (chk_w0) chk({v.nm, "_word0"}, p_w0, v.w0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t r;
    tv[0] = '{"t1_ones", 0, 2, 'h3FF, 0, 0, 40, 64'hFFFF_FFFF_FFFF_FFFF};
    tv[1] = '{"eta2_zero", 2, 2, 0, 0, 0, 12, 64'h2492_4924_9249_2492};
    tv[2] = '{"z3_qm1", 3, 3, Q - 1, 0, 0, 80, 64'h1800_0180_0018_0001};
    tv[3] = '{"t0_5_chg", 1, 5, 0, 5, 0, 52, 64'h0008_0040_0200_1000};
    tv[4] = '{"w1_3", 4, 3, 5, 0, 0, 16, 64'h5555_5555_5555_5555};
    tv[5] = '{"eta3_one", 2, 3, 1, 0, 0, 16, 64'h3333_3333_3333_3333};
    tv[6] = '{"w1_2", 4, 2, 'h3F, 0, 0, 24, 64'hFFFF_FFFF_FFFF_FFFF};
    tv[7] = '{"bad_mode", 6, 7, 'h3FF, 0, 0, 40, 64'hFFFF_FFFF_FFFF_FFFF};
    tv[8] = '{"backpress", 0, 2, 'h3FF, 0, 2, 40, 64'hFFFF_FFFF_FFFF_FFFF};
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_before_edge", ready_o, 0);
    @(posedge clk);
    #1;
    chk("ready_after_rst", ready_o, 1);
    for (int i = 0; i < 9; i++) run_poly(tv[i], 0, 1);
    for (int i = 0; i < 8; i++) begin
      r.nm = "rand";
      r.md = $urandom_range(0, 7);
      r.sc = $urandom_range(0, 7);
      r.c = -1;
      r.chg = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 63)) : 0;
      r.stall = 0;
      r.nw = 4 * bits_of(norm_m(r.md), norm_s(r.sc));
      r.w0 = '0;
      run_poly(r, 1, 0);
    end
    rdy_mode = 0;
    for (int b = 0; b < 10; b++) send_beat(3, 5, $urandom_range(0, Q - 1));
    rst = 1'b1;
    #1;
    chk("rstpulse_valid", valid_o, 0);
    chk("rstpulse_ready", ready_o, 0);
    chk("rstpulse_dout", dout, 0);
    chk("rstpulse_last", last_o, 0);
    valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_pulse", ready_o, 1);
    run_poly(tv[0], 0, 1);
    run_poly(tv[2], 1, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
